// File: rtl/obi_bridge_arbiter_if.sv
// OBI-style request/grant/response bundle used for the two requester ports
// and for the shared bridge port of obi_bridge_arbiter.
// master: the side that issues requests. slave: the side that grants and responds.
interface obi_bridge_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/obi_bridge_arbiter.sv
// obi_bridge_arbiter
// Shares one OBI req/gnt/rvalid slave (the core-to-AXI bridge) between the
// instruction-fetch port and the data port.
//  - round-robin arbitration, with the winner locked while the bridge stalls
//    its grant, so req/addr stay stable as OBI requires
//  - in-order owner FIFO (depth MAX_OUTSTANDING) records who issued each
//    granted transaction; responses are steered to the FIFO head owner
//  - err_o is sticky and flags a response arriving with nothing outstanding
// Optional feature macro: OBI_ARB_PERF_EN adds grant and stall counters
// (instr_gnt_cnt_o, data_gnt_cnt_o, stall_cnt_o).
module obi_bridge_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    obi_bridge_arbiter_if.slave  instr,
    obi_bridge_arbiter_if.slave  data,
    obi_bridge_arbiter_if.master m,
    output logic                 err_o
`ifdef OBI_ARB_PERF_EN
    ,
    output logic [31:0]          instr_gnt_cnt_o,
    output logic [31:0]          data_gnt_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);

    // Pointer width is at least 1 so a depth-1 FIFO still has a legal index;
    // storage is sized to the full pointer range so indexing is always in range.
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DEPTH = 2 ** PTR_W;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // Arbitration state
    owner_e rr_q;       // preferred port when both request
    logic   lock_q;     // a request is on the bus but not yet granted
    owner_e lock_id_q;  // which port holds the lock

    // Owner FIFO state
    owner_e           fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Combinational signals
    owner_e                win_id;
    logic                  win_req;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_we;
    logic [3:0]            win_be;
    logic [31:0]           win_wdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  grant;
    logic                  push;
    logic                  pop;
    owner_e                head_id;

    // Instruction port is read-only; its write-side fields are never forwarded.
    logic unused_instr;
    assign unused_instr = ^{instr.we, instr.be, instr.wdata};

    // Advance a FIFO pointer with explicit wrap at MAX_OUTSTANDING, so a
    // non-power-of-two range of the pointer width is never walked.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head_id    = fifo_q[rd_ptr_q];

    // Winner selection: a locked winner is held, otherwise round-robin when
    // both request, otherwise the single requester.
    always_comb begin
        win_id = OWNER_INSTR;
        if (lock_q) begin
            win_id = lock_id_q;
        end else if (instr.req && data.req) begin
            win_id = rr_q;
        end else if (data.req) begin
            win_id = OWNER_DATA;
        end
    end

    // Request mux: instruction fetches are always full-word reads.
    always_comb begin
        win_req   = instr.req;
        win_addr  = instr.addr;
        win_we    = 1'b0;
        win_be    = 4'b1111;
        win_wdata = '0;
        if (win_id == OWNER_DATA) begin
            win_req   = data.req;
            win_addr  = data.addr;
            win_we    = data.we;
            win_be    = data.be;
            win_wdata = data.wdata;
        end
    end

    // A full owner FIFO blocks the request entirely; it stays pending upstream.
    assign m.req   = win_req && !fifo_full;
    assign m.addr  = win_addr;
    assign m.we    = win_we;
    assign m.be    = win_be;
    assign m.wdata = win_wdata;

    assign grant     = m.req && m.gnt;
    assign instr.gnt = grant && (win_id == OWNER_INSTR);
    assign data.gnt  = grant && (win_id == OWNER_DATA);

    // Responses come back in issue order, so the FIFO head owns each rvalid.
    // A response with nothing outstanding is dropped and flagged on err_o.
    assign push         = grant;
    assign pop          = m.rvalid && !fifo_empty;
    assign instr.rvalid = pop && (head_id == OWNER_INSTR);
    assign data.rvalid  = pop && (head_id == OWNER_DATA);
    assign instr.rdata  = m.rdata;
    assign data.rdata   = m.rdata;

    // Round-robin pointer and grant-pending lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= OWNER_INSTR;
            lock_q    <= 1'b0;
            lock_id_q <= OWNER_INSTR;
        end else begin
            if (grant) begin
                rr_q <= (win_id == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
            end
            lock_q    <= m.req && !m.gnt;
            lock_id_q <= win_id;
        end
    end

    // Owner FIFO: push on grant, pop on a response; both may occur together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= OWNER_INSTR;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= win_id;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky protocol error: response with no outstanding transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (m.rvalid && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

`ifdef OBI_ARB_PERF_EN
    logic stall;
    assign stall = (instr.req && !instr.gnt) || (data.req && !data.gnt);

    // Wrapping per-port grant counters and a cycle counter of blocked requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_gnt_cnt_o <= '0;
            data_gnt_cnt_o  <= '0;
            stall_cnt_o     <= '0;
        end else begin
            if (instr.gnt) instr_gnt_cnt_o <= instr_gnt_cnt_o + 32'd1;
            if (data.gnt)  data_gnt_cnt_o  <= data_gnt_cnt_o + 32'd1;
            if (stall)     stall_cnt_o     <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
